store_split_ctrl: RTL and testbench
===================================

STORE_SPLIT_CTRL -- requirements
Module: store_split_ctrl

Interface
REQ-001 Parameters: none; address width fixed at 32, data width fixed at 32, byte lanes fixed at 4.
REQ-002 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  store request from the core.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_addr  in  32  byte address of the store.
REQ-008 req_funct3  in  3  RISC-V store funct3; [1:0]=00 byte, 01 half, any other value word.
REQ-009 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 mem_req  out  1  memory write request.
REQ-011 mem_gnt  in  1  memory accepts the current write this cycle.
REQ-012 mem_addr  out  32  word-aligned write address; [1:0] always 00.
REQ-013 mem_wmask  out  4  byte write enables; bit i enables byte lane i.
REQ-014 mem_wdata  out  32  lane-aligned write data.
REQ-015 done  out  1  one-cycle pulse when the whole store has completed.

Function
REQ-016 The block SHALL accept a request on a cycle where req_valid and req_ready are both 1, and SHALL capture addr, funct3 and wdata at that cycle.
REQ-017 The block SHALL assert req_ready only in state IDLE.
REQ-018 The block SHALL form the access size as n = 1, 2 or 4 bytes from funct3[1:0], with offset o = addr[1:0].
REQ-019 The block SHALL form an 8-bit mask as ((1<<n)-1)<<o and 64-bit data as wdata<<(8*o); the low halves feed access 1 and the high halves feed access 2.
REQ-020 The store is split if and only if the high 4 mask bits are nonzero.
REQ-021 FSM states SHALL be IDLE, FIRST and SECOND.
- IDLE->FIRST on accept.
- FIRST->SECOND on mem_gnt when the store is split.
- FIRST->IDLE on mem_gnt when it is not split.
- SECOND->IDLE on mem_gnt.
REQ-022 mem_req SHALL be registered and SHALL be 1 throughout FIRST and SECOND; mem_req is asserted the cycle after accept.
REQ-023 In FIRST, mem_addr SHALL equal {addr[31:2],00}; in SECOND, mem_addr SHALL equal that value +4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-024 mem_addr, mem_wmask and mem_wdata SHALL be held stable while mem_req=1 and mem_gnt=0.
REQ-025 done SHALL pulse for exactly one cycle, in the cycle after the final grant; req_ready is 1 in that same cycle.
REQ-026 Minimum throughput: an unsplit store occupies 2 cycles and a split store occupies 3 cycles, measured from accept to the next accept.
REQ-027 In IDLE, mem_req, mem_wmask and mem_wdata SHALL be 0.
REQ-028 mem_gnt while mem_req=0 SHALL be ignored; req_valid while busy SHALL be ignored (no capture).
REQ-029 A byte store never splits; a halfword splits only at o=3; a word splits at any o≠0.

Reset
REQ-030 While rst_n=0, the block SHALL go to state IDLE, and mem_req, mem_addr, mem_wmask, mem_wdata and done SHALL all be 0; req_ready SHALL be 1 after release.
REQ-031 A reset in FIRST or SECOND SHALL abandon the store with no done pulse; the next request after release SHALL be handled normally.

Structure
REQ-032 The shared package SHALL hold the funct3 size encodings (SB=000, SH=001, SW=010) and the FSM state enum.
REQ-033 Mask and data lane generation SHALL live in one combinational sub-module, store_lane_gen (inputs: offset, size, wdata; outputs: mask[7:0], data[63:0]).

Verification
REQ-034 SB, addr 0x1003, data 0xAB, gnt immediate -> exactly one access: addr 0x1000, mask 1000, wdata 0xAB000000, then done.
REQ-035 SH, addr 0x1003, data 0xBEEF -> access 1: 0x1000, mask 1000, wdata 0xEF000000; access 2: 0x1004, mask 0001, wdata 0x000000BE; one done.
REQ-036 SW, addr 0x2002, data 0x11223344 -> access 1: 0x2000, mask 1100, wdata 0x33440000; access 2: 0x2004, mask 0011, wdata 0x00001122.
REQ-037 SW, addr 0xFFFFFFFE -> access 2 has addr 0x00000000 and mask 0011.
REQ-038 SW, addr 0x0, gnt withheld 3 cycles with req_valid toggling -> outputs stable, req_ready 0, no capture; done follows the grant by one cycle.
REQ-039 rst_n pulsed low during SECOND -> mem_req and mask drop to 0 asynchronously, no done; a following SB is processed correctly.

Source files
------------

// File: rtl/store_split_ctrl_pkg.sv
// Shared definitions for the store splitting controller: store size
// encodings (RISC-V funct3) and the controller FSM state type.
package store_split_ctrl_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

endpackage

// File: rtl/store_split_ctrl_lane.sv
// Byte-lane generator: places a right-aligned store into an 8-lane
// (two word) window starting at the byte offset. Lanes 0-3 belong to the
// first word access and lanes 4-7 to the following word.
module store_lane_gen
  import store_split_ctrl_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [7:0]  mask_o,
  output logic [63:0] data_o
);

  logic [7:0] base_mask;

  // Size-dependent base mask, then shift both mask and data to the offset.
  always_comb begin
    if (size_i == F3_SB[1:0]) begin
      base_mask = 8'h01;
    end else if (size_i == F3_SH[1:0]) begin
      base_mask = 8'h03;
    end else begin
      base_mask = 8'h0F;
    end
    mask_o = base_mask << offset_i;
    data_o = {32'h0000_0000, wdata_i} << {offset_i, 3'b000};
  end

endmodule

// File: rtl/store_split_ctrl.sv
// Store splitting controller: turns one possibly misaligned store into one
// or two word-aligned masked memory writes.
// Handshakes: a request is accepted on a cycle with req_valid=1 and
// req_ready=1; a memory write completes on a cycle with mem_req=1 and
// mem_gnt=1, and the write fields stay stable until that cycle.
module store_split_ctrl
  import store_split_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic        done,
  output state_e      dbg_state_o
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  hi_mask_q, hi_mask_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic        done_q, done_d;

  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        unused_funct3_bit;

  // Only funct3[1:0] selects the size; bit 2 does not affect a store.
  assign unused_funct3_bit = req_funct3[2];

  store_lane_gen u_lane_gen (
    .offset_i (req_addr[1:0]),
    .size_i   (req_funct3[1:0]),
    .wdata_i  (req_wdata),
    .mask_o   (lane_mask),
    .data_o   (lane_data)
  );

  // State and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      hi_mask_q <= '0;
      hi_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      hi_mask_q <= hi_mask_d;
      hi_data_q <= hi_data_d;
      done_q    <= done_d;
    end
  end

  // Next state: capture on accept, advance on grant, clear outputs on finish.
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    hi_mask_d = hi_mask_q;
    hi_data_d = hi_data_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_FIRST;
          mem_req_d = 1'b1;
          addr_d    = {req_addr[31:2], 2'b00};
          mask_d    = lane_mask[3:0];
          wdata_d   = lane_data[31:0];
          hi_mask_d = lane_mask[7:4];
          hi_data_d = lane_data[63:32];
        end
      end
      ST_FIRST: begin
        if (mem_gnt) begin
          if (hi_mask_q != 4'b0000) begin
            state_d = ST_SECOND;
            addr_d  = addr_q + 32'd4;
            mask_d  = hi_mask_q;
            wdata_d = hi_data_q;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            addr_d    = '0;
            mask_d    = '0;
            wdata_d   = '0;
            done_d    = 1'b1;
          end
        end
      end
      ST_SECOND: begin
        if (mem_gnt) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          addr_d    = '0;
          mask_d    = '0;
          wdata_d   = '0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        addr_d    = '0;
        mask_d    = '0;
        wdata_d   = '0;
      end
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign mem_wmask   = mask_q;
  assign mem_wdata   = wdata_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_store_split_ctrl.sv
// Bench for store_split_ctrl: directed cases plus randomized stores checked
// against a byte-level reference model.
module tb_store_split_ctrl;
  import store_split_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        done;
  state_e      dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  store_split_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .done        (done),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: walk the store byte by byte into an 8-lane window.
  task automatic model(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                       output int na, output logic [31:0] a0, output logic [31:0] a1,
                       output logic [3:0] m0, output logic [3:0] m1,
                       output logic [31:0] d0, output logic [31:0] d1);
    int n;
    int o;
    logic [7:0]  m8;
    logic [63:0] d64;
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o   = int'(addr[1:0]);
    m8  = '0;
    d64 = '0;
    for (int k = 0; k < 4; k++) begin
      d64[8*(o+k) +: 8] = wd[8*k +: 8];
      if (k < n) m8[o+k] = 1'b1;
    end
    a0 = addr & 32'hFFFF_FFFC;
    a1 = a0 + 32'd4;
    m0 = m8[3:0];
    m1 = m8[7:4];
    d0 = d64[31:0];
    d1 = d64[63:32];
    na = (m1 != 4'b0000) ? 2 : 1;
  endtask

  // Driver: issue one store, hold grant for dl0/dl1 cycles per access,
  // optionally reset during the second access.
  task automatic run_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                           input int dl0, input int dl1, input bit rst2);
    int na;
    int dl;
    logic [31:0] a0, a1, d0, d1, ea, ed;
    logic [3:0]  m0, m1, em;
    model(addr, f3, wd, na, a0, a1, m0, m1, d0, d1);
    chk("ready_pre", req_ready, 1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    req_wdata  = $urandom;
    for (int k = 0; k < na; k++) begin
      dl = (k == 0) ? dl0 : dl1;
      ea = (k == 0) ? a0 : a1;
      em = (k == 0) ? m0 : m1;
      ed = (k == 0) ? d0 : d1;
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wmask", mem_wmask, em);
      chk("mem_wdata", mem_wdata, ed);
      chk("ready_busy", req_ready, 0);
      chk("done_busy", done, 0);
      if (k == 1 && rst2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wmask", mem_wmask, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        chk("rst_done_hold", done, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1);
        return;
      end
      for (int c = 0; c < dl; c++) begin
        mem_gnt    = 1'b0;
        req_valid  = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        req_wdata  = $urandom;
        @(posedge clk); #1;
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, ea);
        chk("hold_wmask", mem_wmask, em);
        chk("hold_wdata", mem_wdata, ed);
        chk("hold_ready", req_ready, 0);
        chk("hold_done", done, 0);
      end
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(posedge clk); #1;
      mem_gnt   = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_ready", req_ready, 1);
    chk("idle_req", mem_req, 0);
    chk("idle_wmask", mem_wmask, 0);
    chk("idle_wdata", mem_wdata, 0);
  endtask

  // Stimulus: reset, directed cases, then randomized stores
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
    mem_gnt    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wmask", mem_wmask, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_done", done, 0);
    chk("reset_state", dbg_state_o, ST_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", req_ready, 1);

    // Stray grant while idle must do nothing.
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("stray_gnt_req", mem_req, 0);
    chk("stray_gnt_done", done, 0);

    run_store(32'h0000_1003, F3_SB, 32'h0000_00AB, 0, 0, 1'b0);
    run_store(32'h0000_1003, F3_SH, 32'h0000_BEEF, 0, 0, 1'b0);
    run_store(32'h0000_2002, F3_SW, 32'h1122_3344, 0, 0, 1'b0);
    run_store(32'hFFFF_FFFE, F3_SW, 32'hCAFE_F00D, 1, 2, 1'b0);
    run_store(32'h0000_0000, F3_SW, 32'hDEAD_BEEF, 3, 0, 1'b0);
    run_store(32'h0000_1003, F3_SH, 32'h0000_BEEF, 0, 1, 1'b1);
    run_store(32'h0000_4001, F3_SB, 32'h0000_005A, 0, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      run_store($urandom, 3'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("gap_done", done, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
